// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller; LSU_MISALIGN_EN enables byte-split misaligned accesses
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWr,
    input  logic [2:0]  ReqCtrl,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    input  logic [31:0] DataRd
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic        wr_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] rsp_data;
    logic        err_q;
    logic        illegal;
    logic        misaligned;
    logic        req_err;

`ifdef LSU_MISALIGN_EN
    logic [1:0]  byte_idx;
    logic [31:0] rd_buf;
    logic [31:0] buf_next;
    logic [31:0] split_result;
    logic [7:0]  store_byte;
    logic        split_last;
`endif

    assign illegal    = (ReqCtrl == 3'b011) || (ReqCtrl[2:1] == 2'b11) || (ReqWr && ReqCtrl[2]);
    assign misaligned = ((ReqCtrl[1:0] == 2'b01) && ReqAddr[0]) ||
                        ((ReqCtrl[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EN
    assign req_err    = illegal;
`else
    assign req_err    = illegal || misaligned;
`endif

`ifdef LSU_MISALIGN_EN
    // Byte lane k of the split access, and the load buffer with byte k merged in
    always_comb begin
        store_byte = 8'h00;
        buf_next   = rd_buf;
        case (byte_idx)
            2'd0: begin store_byte = data_q[7:0];   buf_next[7:0]   = DataRd[7:0]; end
            2'd1: begin store_byte = data_q[15:8];  buf_next[15:8]  = DataRd[7:0]; end
            2'd2: begin store_byte = data_q[23:16]; buf_next[23:16] = DataRd[7:0]; end
            default: begin store_byte = data_q[31:24]; buf_next[31:24] = DataRd[7:0]; end
        endcase
    end

    assign split_last   = ctrl_q[1] ? (byte_idx == 2'd3) : (byte_idx == 2'd1);
    assign split_result = ctrl_q[1] ? buf_next :
                          ctrl_q[2] ? {16'h0000, buf_next[15:0]} :
                                      {{16{buf_next[15]}}, buf_next[15:0]};
`endif

    always_comb begin
        state_next = state;
        ReqReady   = 1'b0;
        RspValid   = 1'b0;
        Address    = 32'h0;
        DataWr     = 32'h0;
        DMWr       = 1'b0;
        DMCtrl     = 3'b010;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    if (req_err)
                        state_next = RESP;
`ifdef LSU_MISALIGN_EN
                    else if (misaligned)
                        state_next = SPLIT;
`endif
                    else
                        state_next = ACCESS;
                end
            end
            ACCESS: begin
                Address    = addr_q;
                DataWr     = data_q;
                DMWr       = wr_q;
                DMCtrl     = ctrl_q;
                state_next = RESP;
            end
`ifdef LSU_MISALIGN_EN
            SPLIT: begin
                Address = addr_q + {30'b0, byte_idx};
                DataWr  = {24'h0, store_byte};
                DMWr    = wr_q;
                DMCtrl  = 3'b000;
                if (split_last)
                    state_next = RESP;
            end
`endif
            RESP: begin
                RspValid   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign RspData = rsp_data;
    assign RspErr  = RspValid && err_q;

    // rsp_data only changes on entry to RESP so it holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            ctrl_q   <= 3'b000;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            rsp_data <= 32'h0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGN_EN
            byte_idx <= 2'd0;
            rd_buf   <= 32'h0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        wr_q   <= ReqWr;
                        ctrl_q <= ReqCtrl;
                        addr_q <= ReqAddr;
                        data_q <= ReqData;
                        err_q  <= req_err;
                        if (req_err)
                            rsp_data <= 32'h0;
`ifdef LSU_MISALIGN_EN
                        byte_idx <= 2'd0;
                        rd_buf   <= 32'h0;
`endif
                    end
                end
                ACCESS: rsp_data <= wr_q ? 32'h0 : DataRd;
`ifdef LSU_MISALIGN_EN
                SPLIT: begin
                    rd_buf   <= buf_next;
                    byte_idx <= byte_idx + 2'd1;
                    if (split_last)
                        rsp_data <= wr_q ? 32'h0 : split_result;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl with byte-array memory and reference model
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWr;
    logic [2:0]  ReqCtrl;
    logic [31:0] ReqAddr;
    logic [31:0] ReqData;
    logic        RspValid;
    logic [31:0] RspData;
    logic        RspErr;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqWr(ReqWr), .ReqCtrl(ReqCtrl), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
        .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] ctrl);
        return (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] raw);
        case (ctrl)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // Data memory: combinational read refreshed mid-cycle, write on the clock edge
    always @(negedge clk) begin
        logic [31:0] tmp;
        tmp = 32'h0;
        for (int k = 0; k < 4; k++)
            tmp[8*k +: 8] = mem_byte(Address + 32'(k));
        DataRd = extend(DMCtrl, tmp);
    end

    always @(posedge clk) begin
        if (DMWr)
            for (int k = 0; k < nbytes(DMCtrl); k++)
                mem[Address + 32'(k)] = DataWr[8*k +: 8];
    end

    task automatic model(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] data, output int lat, output logic err,
                         output logic [31:0] rdata, output int wcnt);
        int n;
        logic bad;
        logic mis;
        logic [31:0] raw;
        n   = nbytes(ctrl);
        bad = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111) || (wr && ctrl[2]);
        mis = (addr % n) != 0;
`ifndef LSU_MISALIGN_EN
        if (mis) bad = 1'b1;
`endif
        if (bad) begin
            lat = 1; err = 1'b1; rdata = 32'h0; wcnt = 0;
        end else begin
            err   = 1'b0;
            lat   = mis ? n + 1 : 2;
            wcnt  = wr ? (mis ? n : 1) : 0;
            rdata = 32'h0;
            if (wr) begin
                for (int k = 0; k < n; k++)
                    ref_mem[addr + 32'(k)] = data[8*k +: 8];
            end else begin
                raw = 32'h0;
                for (int k = 0; k < 4; k++)
                    raw[8*k +: 8] = ref_byte(addr + 32'(k));
                rdata = extend(ctrl, raw);
            end
        end
    endtask

    task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] data);
        int elat, ewcnt, lat, wcnt;
        logic eerr, busy_ready;
        logic [31:0] edata;
        model(wr, ctrl, addr, data, elat, eerr, edata, ewcnt);
        @(posedge clk); #1;
        ReqValid = 1'b1; ReqWr = wr; ReqCtrl = ctrl; ReqAddr = addr; ReqData = data;
        check("ready_idle", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
        // Scramble the request inputs: the accepted request must be latched
        ReqValid = 1'b0;
        ReqWr    = 1'($urandom);
        ReqCtrl  = 3'($urandom);
        ReqAddr  = $urandom;
        ReqData  = $urandom;
        lat = 0; wcnt = 0; busy_ready = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (RspValid) begin
                lat = c;
                break;
            end
            if (DMWr) wcnt++;
            if (ReqReady) busy_ready = 1'b1;
            @(posedge clk); #1;
        end
        check("latency", 32'(lat), 32'(elat));
        check("rsp_err", 32'(RspErr), 32'(eerr));
        check("rsp_data", RspData, edata);
        check("dmwr_count", 32'(wcnt), 32'(ewcnt));
        check("ready_busy", 32'(busy_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after", 32'(ReqReady), 32'd1);
        check("rsp_hold", RspData, edata);
        check("rsp_pulse", 32'(RspValid), 32'd0);
        if (wr && !eerr)
            for (int k = 0; k < 4; k++)
                check("mem_byte", 32'(mem_byte(addr + 32'(k))), 32'(ref_byte(addr + 32'(k))));
    endtask

    initial begin
        int resp_seen;
        logic        r_wr;
        logic [2:0]  r_ctrl;
        logic [31:0] r_addr;

        rst = 1'b1; ReqValid = 1'b1; ReqWr = 1'b1; ReqCtrl = 3'b010;
        ReqAddr = 32'h0; ReqData = 32'h12345678; DataRd = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; ReqValid = 1'b0;
        check("rst_ready", 32'(ReqReady), 32'd1);
        check("rst_rspvalid", 32'(RspValid), 32'd0);
        check("rst_rspdata", RspData, 32'h0);
        check("rst_rsperr", 32'(RspErr), 32'd0);
        check("rst_dmwr", 32'(DMWr), 32'd0);
        check("rst_dmctrl", 32'(DMCtrl), 32'(3'b010));
        check("rst_address", Address, 32'h0);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        do_req(1'b1, 3'b000, 32'h20, 32'h00000080);
        do_req(1'b1, 3'b000, 32'h21, 32'h000000FF);
        do_req(1'b0, 3'b000, 32'h20, 32'h0);
        do_req(1'b0, 3'b100, 32'h20, 32'h0);
        do_req(1'b0, 3'b001, 32'h20, 32'h0);
        do_req(1'b0, 3'b101, 32'h20, 32'h0);
        do_req(1'b1, 3'b100, 32'h0, 32'h55);
        do_req(1'b0, 3'b011, 32'h0, 32'h0);
        do_req(1'b1, 3'b010, 32'h13, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h13, 32'h0);
        do_req(1'b0, 3'b001, 32'h21, 32'h0);
        do_req(1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD);
`ifdef LSU_MISALIGN_EN
        check("wrap_byte0", 32'(mem_byte(32'h0)), 32'h000000BB);
        check("wrap_byte1", 32'(mem_byte(32'h1)), 32'h000000AA);
`endif

        for (int i = 0; i < 150; i++) begin
            r_wr   = 1'($urandom);
            r_ctrl = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                r_addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else
                r_addr = 32'($urandom_range(0, 63));
            do_req(r_wr, r_ctrl, r_addr, $urandom);
        end

`ifdef LSU_MISALIGN_EN
        do_req(1'b1, 3'b000, 32'h34, 32'h5A);
        @(posedge clk); #1;
        ReqValid = 1'b1; ReqWr = 1'b1; ReqCtrl = 3'b010; ReqAddr = 32'h31; ReqData = 32'hCAFEBABE;
        check("abort_ready", 32'(ReqReady), 32'd1);
        @(posedge clk); #1;
        ReqValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_dmwr", 32'(DMWr), 32'd0);
        check("abort_ready_after", 32'(ReqReady), 32'd1);
        check("abort_rspdata", RspData, 32'h0);
        resp_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (RspValid) resp_seen++;
            @(posedge clk); #1;
        end
        check("abort_no_resp", 32'(resp_seen), 32'd0);
        check("abort_byte0", 32'(mem_byte(32'h31)), 32'h000000BE);
        check("abort_byte1", 32'(mem_byte(32'h32)), 32'h000000BA);
        check("abort_byte3", 32'(mem_byte(32'h34)), 32'h0000005A);
`endif
        do_req(1'b0, 3'b010, 32'h10, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
